led_pattern_seq: RTL

Parametrised LED pattern sequencer driving a bank of `LED_W` LEDs from the board master clock. It contains an internal prescaler with run-time speed select and five run-time selectable patterns: shift left, shift right, ping-pong bounce, bar fill and blink. It also provides pause and a one-cycle step strobe. It sits between the board clock and the LED pins and is the general replacement for fixed-pattern LED runners in our demo designs.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_prescaler.sv | 46 ++++
 rtl/led_pattern_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode encodings and bounce direction type for the LED sequencer
package led_pkg;

  localparam logic [2:0] MODE_LEFT   = 3'd0;
  localparam logic [2:0] MODE_RIGHT  = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_FILL   = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step-rate prescaler with speed select, pause and clear
module led_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       clr,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] term;

  always_comb begin
    term = PW'(TICK_DIV - 1);
    case (speed)
      2'd0: term = PW'(TICK_DIV - 1);
      2'd1: term = PW'((TICK_DIV >> 1) - 1);
      2'd2: term = PW'((TICK_DIV >> 2) - 1);
      2'd3: term = PW'((TICK_DIV >> 3) - 1);
      default: term = PW'(TICK_DIV - 1);
    endcase
  end

  // >= rather than == so a speed-up past the current count still wraps at once
  assign tick = !pause && (pcnt >= term);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (pause) begin
      pcnt <= pcnt;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED pattern sequencer: pattern registers, bounce FSM and mode tracking
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step
);

  localparam int POS_W = $clog2(LED_W);
  localparam logic [LED_W-1:0] ONE = LED_W'(1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);

  logic [2:0]       mode_q;
  logic [2:0]       mode_act;
  logic [2:0]       mode_act_n;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_n;
  dir_t             dir;
  dir_t             dir_n;
  logic [LED_W-1:0] led_n;
  logic             step_n;
  logic             chg;
  logic             tick;

  // mode_q is the sampled input; mode_act is the pattern actually running
  assign chg = (mode_q != mode_act);

  led_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .mclk (mclk),
    .rst_n(rst_n),
    .speed(speed),
    .pause(pause),
    .clr  (chg),
    .tick (tick)
  );

  always_comb begin
    mode_act_n = mode_act;
    pos_n      = pos;
    dir_n      = dir;
    led_n      = led;
    step_n     = 1'b0;
    if (chg) begin
      mode_act_n = mode_q;
      pos_n      = '0;
      dir_n      = DIR_UP;
      step_n     = 1'b1;
      case (mode_q)
        MODE_LEFT:   led_n = ONE;
        MODE_RIGHT:  led_n = ONE << (LED_W - 1);
        MODE_BOUNCE: led_n = ONE;
        MODE_FILL:   led_n = '0;
        MODE_BLINK:  led_n = '1;
        default:     led_n = '0;
      endcase
    end else if (tick) begin
      case (mode_act)
        MODE_LEFT: begin
          led_n  = {led[LED_W-2:0], led[LED_W-1]};
          step_n = 1'b1;
        end
        MODE_RIGHT: begin
          led_n  = {led[0], led[LED_W-1:1]};
          step_n = 1'b1;
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos == POS_MAX) begin
              dir_n = DIR_DOWN;
              pos_n = pos - POS_W'(1);
            end else begin
              pos_n = pos + POS_W'(1);
            end
          end else begin
            if (pos == '0) begin
              dir_n = DIR_UP;
              pos_n = POS_W'(1);
            end else begin
              pos_n = pos - POS_W'(1);
            end
          end
          led_n  = ONE << pos_n;
          step_n = 1'b1;
        end
        MODE_FILL: begin
          led_n  = (&led) ? '0 : {led[LED_W-2:0], 1'b1};
          step_n = 1'b1;
        end
        MODE_BLINK: begin
          led_n  = ~led;
          step_n = 1'b1;
        end
        default: led_n = '0;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 3'd0;
      mode_act <= 3'd0;
      pos      <= '0;
      dir      <= DIR_UP;
      led      <= ONE;
      step     <= 1'b0;
    end else begin
      mode_q   <= mode;
      mode_act <= mode_act_n;
      pos      <= pos_n;
      dir      <= dir_n;
      led      <= led_n;
      step     <= step_n;
    end
  end

endmodule
